// File: rtl/kalman_chan_scheduler.sv
// kalman_chan_scheduler
// Shares one sequential 8-bit scalar Kalman estimator among NCH ADC channels.
// Each channel keeps its own covariance P and estimate. Requesters are served
// round-robin, Q/R are sampled at grant, and results leave as a single stream
// tagged with the producing channel.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid[NCH]        per-channel sample valid
//   in_data[NCH*8]       per-channel sample, channel c at [8c+7:8c]
//   in_ready[NCH]        one-hot grant, only in IDLE
//   q_cfg, r_cfg         process / observation noise, sampled at grant
//   clr                  pulse; zeroes all channel state at the next IDLE
//   out_valid/out_ready  result handshake
//   out_data, out_ch     filtered estimate and its channel
//   busy                 high whenever the FSM is not in IDLE
//
// Build option: define KALMAN_SEED_EN so the first job of each channel after
// reset/clr loads est=x and P=R instead of running the Kalman update.
//
// state | meaning
// IDLE  | apply pending clear, else arbitrate and accept one sample
// PRED  | Pp = sat16(P + Q)
// DIV   | 8-cycle restoring divide, Kg = (Pp<<8)/(Pp+R)
// UPD   | write back est and P for the channel, load output regs
// OUT   | hold result until out_ready
module kalman_chan_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*8-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic [7:0]       q_cfg,
  input  logic [7:0]       r_cfg,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CW-1:0]    out_ch,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_PRED, S_DIV, S_UPD, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [7:0]      x_q, x_d, q_q, q_d, r_q, r_d;
  logic [15:0]     pp_q, pp_d;
  logic [16:0]     rem_q, rem_d;
  logic [7:0]      kg_q, kg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            clr_pend_q, clr_pend_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic [15:0]     p_q [NCH];
  logic [15:0]     p_d [NCH];
  logic [7:0]      est_q [NCH];
  logic [7:0]      est_d [NCH];
`ifdef KALMAN_SEED_EN
  logic [NCH-1:0]  seeded_q, seeded_d;
`endif

  logic [7:0]      in_arr [NCH];
  logic            any_req;
  logic [CW-1:0]   gnt_idx;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign in_arr[c] = in_data[8*c+7:8*c];
  end

  // Search starts one past the last grant so every requester is reached
  // within NCH jobs.
  always_comb begin
    any_req = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!any_req && in_valid[CW'((int'(last_q) + i) % NCH)]) begin
        any_req = 1'b1;
        gnt_idx = CW'((int'(last_q) + i) % NCH);
      end
    end
  end

  // Datapath
  logic [16:0] pp_sum, div_val;
  logic [15:0] pp_sat, p_new;
  logic [17:0] rem_sh;
  logic        rem_ge, x_gt;
  logic [7:0]  kg_eff, est_cur, diff, step, est_new;
  logic [15:0] prod;
  logic [24:0] p_prod;

  assign pp_sum  = {1'b0, p_q[ch_q]} + {9'd0, q_q};
  assign pp_sat  = pp_sum[16] ? 16'hFFFF : pp_sum[15:0];
  // Pp+R can need 17 bits; the shifted remainder stays below 2*(Pp+R).
  assign div_val = {1'b0, pp_q} + {9'd0, r_q};
  assign rem_sh  = {rem_q, 1'b0};
  assign rem_ge  = rem_sh >= {1'b0, div_val};
  // R=0 gives quotient 256 (or 0/0); clamp to unity gain.
  assign kg_eff  = (r_q == 8'd0) ? 8'hFF : kg_q;
  assign est_cur = est_q[ch_q];
  assign x_gt    = x_q > est_cur;
  assign diff    = x_gt ? (x_q - est_cur) : (est_cur - x_q);
  assign prod    = {8'd0, kg_eff} * {8'd0, diff};
  // step < diff since Kg <= 255, so est_new cannot wrap.
  assign step    = 8'(prod >> 8);
  assign est_new = x_gt ? (est_cur + step) : (est_cur - step);
  assign p_prod  = {16'd0, 9'd256 - {1'b0, kg_eff}} * {9'd0, pp_q};
  assign p_new   = 16'(p_prod >> 8);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ch_d       = ch_q;
    x_d        = x_q;
    q_d        = q_q;
    r_d        = r_q;
    pp_d       = pp_q;
    rem_d      = rem_q;
    kg_d       = kg_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q | clr;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    p_d        = p_q;
    est_d      = est_q;
`ifdef KALMAN_SEED_EN
    seeded_d   = seeded_q;
`endif
    in_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (clr || clr_pend_q) begin
          for (int c = 0; c < NCH; c++) begin
            p_d[c]   = '0;
            est_d[c] = '0;
          end
`ifdef KALMAN_SEED_EN
          seeded_d = '0;
`endif
          clr_pend_d = 1'b0;
        end else if (any_req) begin
          in_ready[gnt_idx] = 1'b1;
          ch_d    = gnt_idx;
          x_d     = in_arr[gnt_idx];
          q_d     = q_cfg;
          r_d     = r_cfg;
          last_d  = gnt_idx;
          state_d = S_PRED;
        end
      end
      S_PRED: begin
        pp_d    = pp_sat;
        rem_d   = {1'b0, pp_sat};
        kg_d    = '0;
        cnt_d   = 3'd7;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (rem_ge) begin
          rem_d = 17'(rem_sh - {1'b0, div_val});
          kg_d  = {kg_q[6:0], 1'b1};
        end else begin
          rem_d = 17'(rem_sh);
          kg_d  = {kg_q[6:0], 1'b0};
        end
        if (cnt_q == 3'd0) state_d = S_UPD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_UPD: begin
        est_d[ch_q] = est_new;
        p_d[ch_q]   = p_new;
        out_data_d  = est_new;
`ifdef KALMAN_SEED_EN
        if (!seeded_q[ch_q]) begin
          est_d[ch_q] = x_q;
          p_d[ch_q]   = {8'd0, r_q};
          out_data_d  = x_q;
        end
        seeded_d[ch_q] = 1'b1;
`endif
        out_ch_d = ch_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= CW'(NCH - 1);
      ch_q       <= '0;
      x_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      pp_q       <= '0;
      rem_q      <= '0;
      kg_q       <= '0;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        p_q[c]   <= '0;
        est_q[c] <= '0;
      end
`ifdef KALMAN_SEED_EN
      seeded_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      x_q        <= x_d;
      q_q        <= q_d;
      r_q        <= r_d;
      pp_q       <= pp_d;
      rem_q      <= rem_d;
      kg_q       <= kg_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      p_q        <= p_d;
      est_q      <= est_d;
`ifdef KALMAN_SEED_EN
      seeded_q   <= seeded_d;
`endif
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
